fsm: RTL and testbench
======================

Name: fsm

Overview:
- Parking-lot access controller. It tracks occupancy and decides, once per clock, whether a requested car entry or exit is granted.
- Each clock it samples a 4-bit request/mode bus. It outputs the current occupancy count and a one-cycle door-open pulse for every granted movement.
- It sits between the gate sensors and mode switches on one side and the door actuator and occupancy display on the other.

Parameters:
- CAPACITY, 10: maximum number of parked cars. Legal range 1..15 so the count fits in 4 bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in  input  4  request/mode bus: in[3]=entry request, in[2]=exit request, in[1:0]=mode switch.
- state  output  4  registered occupancy count, 0..CAPACITY.
- door_open_pulse  output  1  registered; high for exactly one cycle after a granted movement.

Behaviour:
- Reset: on a rising clk with rst=1, state<=0 and door_open_pulse<=0. rst has priority over all requests.
- Requests are level-sensitive and sampled every rising edge. Each cycle with entry or exit high counts as one request, so a request held high for N cycles is N requests.
- Mode in[1:0]:
  - 00 normal: entry and exit both enabled.
  - 01 entry-closed: entries refused, exits enabled.
  - 10 exit-closed: exits refused, entries enabled.
  - 11 lockdown: both refused.
- Grant rules, evaluated on the pre-edge count:
  - entry_ok = entry & entry enabled by mode & (count < CAPACITY).
  - exit_ok = exit & exit enabled by mode & (count > 0).
- Count update at the edge:
  - entry_ok only: count+1.
  - exit_ok only: count-1.
  - both granted (simultaneous entry and exit): count unchanged.
  - neither granted: unchanged.
- The count never wraps. Entry at CAPACITY is refused (saturates) and exit at 0 is refused.
- door_open_pulse <= entry_ok | exit_ok. It appears in the same edge as the count update and lasts one cycle.
  - A simultaneous double grant gives a single 1-cycle pulse.
  - Consecutive grants keep it high on consecutive cycles.
  - A refused request gives door_open_pulse=0 and leaves the count unchanged.
- Suggested internal structure: mode decode, grant logic, count register, pulse register. No hidden states beyond count and pulse.
- Reset mid-operation: next edge clears count and pulse regardless of in. Requests sampled during that edge are discarded.
- X/unknown inputs are out of scope. The outputs are fully registered, with no combinational path from in to outputs.

Test Plan:
- Reset check: rst=1 for 2 cycles with in=1100 -> state=0000, door_open_pulse=0. Release rst, in=0000 -> outputs stay 0.
- Normal entry: in=1000 for 3 cycles -> state 0001, 0010, 0011, pulse high each of those cycles. Then in=0000 -> state=0011, pulse=0.
- Exit and empty boundary: from state=0001, in=0100 -> state=0000 with a pulse. Next in=0100 -> state=0000, pulse=0 (refused at empty).
- Full boundary: drive in=1000 until state=1010 (CAPACITY=10). One more in=1000 -> state=1010, pulse=0. Then in=0100 -> state=1001 with a pulse.
- Modes: at state=0011:
  - in=1001 -> refused, 0011, pulse 0.
  - in=0101 -> 0010 with pulse.
  - in=0110 -> refused.
  - in=1110 -> entry only, 0011 with pulse.
  - in=1111 -> refused.
- Simultaneous and reset mid-run:
  - in=1100 at state=0101 -> state=0101, single pulse.
  - in=1100 at state=0000 -> entry only, 0001 with pulse.
  - rst=1 with in=1000 at state=0100 -> state=0000, pulse 0.

Source files
------------

// File: rtl/fsm.sv
// Parking-lot access controller.
// Tracks how many cars are parked and grants entry or exit requests once per
// clock. The grant decision uses the occupancy count from before the edge.
// When both an entry and an exit are granted in the same cycle the count
// stays the same, but the door still opens once. Both outputs are registered,
// so no combinational path runs from `in` to either output.
module fsm #(
  parameter int unsigned CAPACITY = 10  // legal range 1..15 so the count fits in 4 bits
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in,
  output logic [3:0] state,
  output logic       door_open_pulse
);

  // Capacity narrowed to the width of the count register.
  localparam logic [3:0] CAP_L = 4'(CAPACITY);

  // Gate mode switch encoding.
  typedef enum logic [1:0] {
    MODE_NORMAL       = 2'b00,
    MODE_ENTRY_CLOSED = 2'b01,
    MODE_EXIT_CLOSED  = 2'b10,
    MODE_LOCKDOWN     = 2'b11
  } mode_t;

  // Fields of the request/mode bus.
  logic       w_entry_req;
  logic       w_exit_req;
  mode_t      w_mode;

  // Outputs of the mode decode.
  logic       w_entry_en;
  logic       w_exit_en;

  // Grant decisions and the next count.
  logic       w_entry_ok;
  logic       w_exit_ok;
  logic [3:0] w_count_nxt;

  // Registered state.
  logic [3:0] r_count;
  logic       r_pulse;

  // Next count given the two grants. The guards in the grant logic already
  // keep the count from wrapping, so a plain +1/-1 is enough here.
  function automatic logic [3:0] next_count(input logic [3:0] cnt,
                                            input logic       ent_ok,
                                            input logic       ext_ok);
    logic [3:0] res;
    res = cnt;
    unique case ({ent_ok, ext_ok})
      2'b10:   res = cnt + 4'd1;
      2'b01:   res = cnt - 4'd1;
      default: res = cnt;       // neither granted, or both granted (net zero)
    endcase
    return res;
  endfunction

  // Split the request/mode bus into its fields.
  assign w_entry_req = in[3];
  assign w_exit_req  = in[2];
  assign w_mode      = mode_t'(in[1:0]);

  // Mode decode: which directions the switch currently allows.
  always_comb begin
    w_entry_en = 1'b0;
    w_exit_en  = 1'b0;
    unique case (w_mode)
      MODE_NORMAL: begin
        w_entry_en = 1'b1;
        w_exit_en  = 1'b1;
      end
      MODE_ENTRY_CLOSED: begin
        w_entry_en = 1'b0;
        w_exit_en  = 1'b1;
      end
      MODE_EXIT_CLOSED: begin
        w_entry_en = 1'b1;
        w_exit_en  = 1'b0;
      end
      MODE_LOCKDOWN: begin
        w_entry_en = 1'b0;
        w_exit_en  = 1'b0;
      end
      default: begin
        w_entry_en = 1'b0;
        w_exit_en  = 1'b0;
      end
    endcase
  end

  // Grant logic on the pre-edge count. An entry is refused when the lot is
  // full, and an exit is refused when the lot is empty.
  always_comb begin
    w_entry_ok  = w_entry_req & w_entry_en & (r_count < CAP_L);
    w_exit_ok   = w_exit_req  & w_exit_en  & (r_count != 4'd0);
    w_count_nxt = next_count(r_count, w_entry_ok, w_exit_ok);
  end

  // Occupancy register and door pulse. Reset overrides and discards any
  // request sampled on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 4'd0;
      r_pulse <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_pulse <= w_entry_ok | w_exit_ok;
    end
  end

  assign state           = r_count;
  assign door_open_pulse = r_pulse;

endmodule

// File: tb/tb_fsm.sv
// Directed testbench for the parking-lot controller (CAPACITY = 10).
// Inputs change on the falling edge. Outputs are sampled 1 ns after the
// rising edge.
`timescale 1ns/1ps
module tb_fsm;

  logic       clk;
  logic       rst;
  logic [3:0] in;
  logic [3:0] state;
  logic       door_open_pulse;

  int n_vec;
  int n_err;

  fsm #(.CAPACITY(10)) dut (
    .clk             (clk),
    .rst             (rst),
    .in              (in),
    .state           (state),
    .door_open_pulse (door_open_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare {state, pulse} against the expected value and count the result.
  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got state=%0d pulse=%0b, want state=%0d pulse=%0b",
               tag, got[4:1], got[0], exp[4:1], exp[0]);
    end
  endtask

  // Apply one cycle of stimulus, then check the registered result.
  task automatic step(input string tag, input logic r, input logic [3:0] v,
                      input int exp_state, input logic exp_pulse);
    @(negedge clk);
    rst = r;
    in  = v;
    @(posedge clk);
    #1;
    chk(tag, {state, door_open_pulse}, {4'(exp_state), exp_pulse});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    in    = 4'b1100;

    // Reset has priority over requests.
    step("rst0", 1'b1, 4'b1100, 0, 1'b0);
    step("rst1", 1'b1, 4'b1100, 0, 1'b0);
    step("idle", 1'b0, 4'b0000, 0, 1'b0);

    // Normal entries give consecutive pulses.
    step("ent1", 1'b0, 4'b1000, 1, 1'b1);
    step("ent2", 1'b0, 4'b1000, 2, 1'b1);
    step("ent3", 1'b0, 4'b1000, 3, 1'b1);
    step("hold", 1'b0, 4'b0000, 3, 1'b0);

    // Exits down to the empty boundary.
    step("ext2", 1'b0, 4'b0100, 2, 1'b1);
    step("ext1", 1'b0, 4'b0100, 1, 1'b1);
    step("ext0", 1'b0, 4'b0100, 0, 1'b1);
    step("extE", 1'b0, 4'b0100, 0, 1'b0);

    // Fill to capacity, then try one more entry.
    for (int i = 1; i <= 10; i++) step("fill", 1'b0, 4'b1000, i, 1'b1);
    step("full", 1'b0, 4'b1000, 10, 1'b0);
    step("fulx", 1'b0, 4'b0100, 9, 1'b1);

    // Exit down to 3.
    for (int i = 8; i >= 3; i--) step("drain", 1'b0, 4'b0100, i, 1'b1);

    // Mode checks starting at 3.
    step("m01e", 1'b0, 4'b1001, 3, 1'b0);
    step("m01x", 1'b0, 4'b0101, 2, 1'b1);
    step("m10x", 1'b0, 4'b0110, 2, 1'b0);
    step("m10b", 1'b0, 4'b1110, 3, 1'b1);
    step("m11b", 1'b0, 4'b1111, 3, 1'b0);
    step("m11x", 1'b0, 4'b0111, 3, 1'b0);

    // Simultaneous entry and exit at 5.
    step("to4",  1'b0, 4'b1000, 4, 1'b1);
    step("to5",  1'b0, 4'b1000, 5, 1'b1);
    step("both", 1'b0, 4'b1100, 5, 1'b1);
    step("quiet", 1'b0, 4'b0000, 5, 1'b0);

    // Reset while running, then a simultaneous request at 0 (only the entry is granted).
    step("rstm", 1'b1, 4'b1100, 0, 1'b0);
    step("bth0", 1'b0, 4'b1100, 1, 1'b1);
    step("to2",  1'b0, 4'b1000, 2, 1'b1);
    step("to3",  1'b0, 4'b1000, 3, 1'b1);
    step("to4b", 1'b0, 4'b1000, 4, 1'b1);
    step("rstr", 1'b1, 4'b1000, 0, 1'b0);
    step("post", 1'b0, 4'b0000, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
